// File: rtl/eth_rx_fcs_check.sv
// Receive-side Ethernet FCS checker: CRC-32 residue check, FCS strip via a one-beat hold
// register, per-frame length/PHY error flags and saturating frame statistics.
module eth_rx_fcs_check #(
   parameter int unsigned MIN_FRAME = 64,
   parameter int unsigned MAX_FRAME = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] in_data,
   input  logic [7:0]  in_keep,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic        in_err,
   output logic [63:0] out_data,
   output logic [7:0]  out_keep,
   output logic        out_valid,
   output logic        out_last,
   output logic        out_fcs_err,
   output logic        out_len_err,
   output logic        out_phy_err,
   output logic [31:0] stat_good,
   output logic [31:0] stat_bad_fcs,
   output logic [31:0] stat_len_err
);

   localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
   localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
   localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

   typedef enum logic [1:0] {StEmpty, StHold, StFlush} state_e;

   // Reflected CRC-32 update for one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
      end
      return c;
   endfunction

   // Contiguous keep of k lanes starting at lane 0 (k = 0..8).
   function automatic logic [7:0] lane_mask(input logic [3:0] k);
      logic [8:0] m;
      m = (9'd1 << k) - 9'd1;
      return m[7:0];
   endfunction

   // Expand a byte keep into a bit mask so stripped FCS bytes never leak onto out_data.
   function automatic logic [63:0] byte_mask(input logic [7:0] keep);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) begin
         m[8*i +: 8] = {8{keep[i]}};
      end
      return m;
   endfunction

   state_e      st_q, st_d;
   logic [63:0] hold_data_q, hold_data_d;
   logic [7:0]  hold_keep_q, hold_keep_d;
   logic        pend_fcs_q, pend_fcs_d;
   logic        pend_len_q, pend_len_d;
   logic        pend_phy_q, pend_phy_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] len_q, len_d;
   logic        phy_q, phy_d;

   logic [63:0] out_data_q, out_data_d;
   logic [7:0]  out_keep_q, out_keep_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        out_fcs_q, out_fcs_d;
   logic        out_len_q, out_len_d;
   logic        out_phy_q, out_phy_d;
   logic [31:0] stat_good_q, stat_good_d;
   logic [31:0] stat_fcs_q, stat_fcs_d;
   logic [31:0] stat_len_q, stat_len_d;

   logic [7:0]  keep_eff;
   logic [3:0]  n_bytes;
   logic [31:0] crc_calc;
   logic [16:0] len_add;
   logic [15:0] len_tot;
   logic        frame_fcs_err;
   logic        frame_len_err;
   logic        frame_phy_err;

   // Effective lane count, CRC over enabled lanes and running length for this beat.
   always_comb begin
      keep_eff = in_last ? in_keep : 8'hFF;
      n_bytes  = '0;
      crc_calc = crc_q;
      for (int i = 0; i < 8; i++) begin
         n_bytes = n_bytes + {3'b000, keep_eff[i]};
         if (keep_eff[i]) begin
            crc_calc = crc_byte(crc_calc, in_data[8*i +: 8]);
         end
      end
      len_add       = {1'b0, len_q} + {13'h0, n_bytes};
      len_tot       = len_add[16] ? 16'hFFFF : len_add[15:0];
      frame_fcs_err = (crc_calc != CrcResidue);
      frame_len_err = (32'(len_tot) < MIN_FRAME) || (32'(len_tot) > MAX_FRAME);
      frame_phy_err = phy_q | in_err;
   end

   // Per-frame accumulators: advance on accepted beats, reinitialise after the last beat.
   always_comb begin
      crc_d = crc_q;
      len_d = len_q;
      phy_d = phy_q;
      if (in_valid) begin
         if (in_last) begin
            crc_d = CrcInit;
            len_d = '0;
            phy_d = 1'b0;
         end else begin
            crc_d = crc_calc;
            len_d = len_tot;
            phy_d = frame_phy_err;
         end
      end
   end

   // Saturating statistics, one update per frame on its last input beat.
   always_comb begin
      stat_good_d = stat_good_q;
      stat_fcs_d  = stat_fcs_q;
      stat_len_d  = stat_len_q;
      if (in_valid && in_last) begin
         if (!frame_fcs_err && !frame_len_err && !frame_phy_err && (stat_good_q != '1)) begin
            stat_good_d = stat_good_q + 32'd1;
         end
         if (frame_fcs_err && (stat_fcs_q != '1)) begin
            stat_fcs_d = stat_fcs_q + 32'd1;
         end
         if (frame_len_err && (stat_len_q != '1)) begin
            stat_len_d = stat_len_q + 32'd1;
         end
      end
   end

   // Hold-register FSM: delays the stream by one beat so the trailing 4 FCS bytes can be cut.
   always_comb begin
      st_d        = st_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      pend_fcs_d  = pend_fcs_q;
      pend_len_d  = pend_len_q;
      pend_phy_d  = pend_phy_q;
      out_data_d  = '0;
      out_keep_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_fcs_d   = 1'b0;
      out_len_d   = 1'b0;
      out_phy_d   = 1'b0;

      // FLUSH drains unconditionally; the hold register is then free for an incoming beat.
      if (st_q == StFlush) begin
         out_valid_d = 1'b1;
         out_last_d  = 1'b1;
         out_keep_d  = hold_keep_q;
         out_data_d  = hold_data_q & byte_mask(hold_keep_q);
         out_fcs_d   = pend_fcs_q;
         out_len_d   = pend_len_q;
         out_phy_d   = pend_phy_q;
         st_d        = StEmpty;
      end

      if (in_valid) begin
         if (!in_last) begin
            if (st_q == StHold) begin
               out_valid_d = 1'b1;
               out_keep_d  = 8'hFF;
               out_data_d  = hold_data_q;
            end
            hold_data_d = in_data;
            hold_keep_d = 8'hFF;
            st_d        = StHold;
         end else if (n_bytes <= 4'd4) begin
            // FCS straddles the held beat: trim its top (4 - n) bytes and close the frame.
            if (st_q == StHold) begin
               out_valid_d = 1'b1;
               out_last_d  = 1'b1;
               out_keep_d  = lane_mask(n_bytes + 4'd4);
               out_data_d  = hold_data_q & byte_mask(lane_mask(n_bytes + 4'd4));
               out_fcs_d   = frame_fcs_err;
               out_len_d   = frame_len_err;
               out_phy_d   = frame_phy_err;
            end
            st_d = StEmpty;
         end else begin
            if (st_q == StHold) begin
               out_valid_d = 1'b1;
               out_keep_d  = 8'hFF;
               out_data_d  = hold_data_q;
            end
            hold_data_d = in_data;
            hold_keep_d = lane_mask(n_bytes - 4'd4);
            pend_fcs_d  = frame_fcs_err;
            pend_len_d  = frame_len_err;
            pend_phy_d  = frame_phy_err;
            st_d        = StFlush;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q        <= StEmpty;
         hold_data_q <= '0;
         hold_keep_q <= '0;
         pend_fcs_q  <= 1'b0;
         pend_len_q  <= 1'b0;
         pend_phy_q  <= 1'b0;
         crc_q       <= CrcInit;
         len_q       <= '0;
         phy_q       <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_fcs_q   <= 1'b0;
         out_len_q   <= 1'b0;
         out_phy_q   <= 1'b0;
         stat_good_q <= '0;
         stat_fcs_q  <= '0;
         stat_len_q  <= '0;
      end else begin
         st_q        <= st_d;
         hold_data_q <= hold_data_d;
         hold_keep_q <= hold_keep_d;
         pend_fcs_q  <= pend_fcs_d;
         pend_len_q  <= pend_len_d;
         pend_phy_q  <= pend_phy_d;
         crc_q       <= crc_d;
         len_q       <= len_d;
         phy_q       <= phy_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_fcs_q   <= out_fcs_d;
         out_len_q   <= out_len_d;
         out_phy_q   <= out_phy_d;
         stat_good_q <= stat_good_d;
         stat_fcs_q  <= stat_fcs_d;
         stat_len_q  <= stat_len_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_keep     = out_keep_q;
   assign out_valid    = out_valid_q;
   assign out_last     = out_last_q;
   assign out_fcs_err  = out_fcs_q;
   assign out_len_err  = out_len_q;
   assign out_phy_err  = out_phy_q;
   assign stat_good    = stat_good_q;
   assign stat_bad_fcs = stat_fcs_q;
   assign stat_len_err = stat_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: builds frames with known FCS, collects the stripped
// output stream and per-frame flags, and compares against bench-computed expectations.
module tb_eth_rx_fcs_check;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic [7:0]  in_keep;
   logic        in_valid, in_last, in_err;
   logic [63:0] out_data;
   logic [7:0]  out_keep;
   logic        out_valid, out_last, out_fcs_err, out_len_err, out_phy_err;
   logic [31:0] stat_good, stat_bad_fcs, stat_len_err;

   always #5 clk = ~clk;

   eth_rx_fcs_check #(
      .MIN_FRAME(64),
      .MAX_FRAME(1518)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_keep     (in_keep),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_err      (in_err),
      .out_data    (out_data),
      .out_keep    (out_keep),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_fcs_err (out_fcs_err),
      .out_len_err (out_len_err),
      .out_phy_err (out_phy_err),
      .stat_good   (stat_good),
      .stat_bad_fcs(stat_bad_fcs),
      .stat_len_err(stat_len_err)
   );

   typedef struct {
      logic [7:0]  keep;
      logic [63:0] data;
      logic        fcs;
      logic        len;
      logic        phy;
      int          cyc;
   } last_rec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         last_cyc_q[$];
   last_rec_t  rec_q[$];
   int         beat_cnt, short_cnt, viol_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Output collector, sampled on the falling edge.
   always @(negedge clk) begin
      if (out_valid) begin
         beat_cnt++;
         for (int i = 0; i < 8; i++) begin
            if (out_keep[i]) rx_q.push_back(out_data[8*i +: 8]);
         end
         if (out_last) begin
            last_rec_t r;
            r.keep = out_keep;
            r.data = out_data;
            r.fcs  = out_fcs_err;
            r.len  = out_len_err;
            r.phy  = out_phy_err;
            r.cyc  = cyc;
            rec_q.push_back(r);
         end else begin
            if (out_keep != 8'hFF) short_cnt++;
            if (out_fcs_err || out_len_err || out_phy_err) viol_cnt++;
         end
      end else if (out_last || out_fcs_err || out_len_err || out_phy_err) begin
         viol_cnt++;
      end
   end

   task automatic clear_mon();
      rx_q.delete();
      exp_q.delete();
      rec_q.delete();
      last_cyc_q.delete();
      beat_cnt  = 0;
      short_cnt = 0;
      viol_cnt  = 0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_err   = 1'b0;
      in_keep  = 8'h00;
      in_data  = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      clear_mon();
   endtask

   // Payload pattern plus FCS (complemented CRC, least significant byte first).
   task automatic build_frame(input int len, input int seed);
      logic [31:0] c;
      logic [7:0]  b;
      logic        fb;
      c = 32'hFFFF_FFFF;
      tx_q.delete();
      for (int i = 0; i < len - 4; i++) begin
         b = 8'((i * 13) + seed);
         tx_q.push_back(b);
         exp_q.push_back(b);
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[j];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      c = ~c;
      for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
   endtask

   // Drives tx_q as beats. abort_beat: drive that beat and return without clocking it.
   task automatic send_frame(input int gap_after, input int gap_len, input int err_beat,
                             input bit junk_keep, input int abort_beat);
      int nb;
      nb = (tx_q.size() + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         logic [63:0] d;
         logic [7:0]  k;
         d = '0;
         k = '0;
         for (int i = 0; i < 8; i++) begin
            if (8*b + i < tx_q.size()) begin
               d[8*i +: 8] = tx_q[8*b + i];
               k[i]        = 1'b1;
            end
         end
         in_data  = d;
         in_last  = (b == nb - 1);
         in_keep  = (junk_keep && !in_last) ? 8'h00 : k;
         in_valid = 1'b1;
         in_err   = (b == err_beat);
         if (b == abort_beat) return;
         if (in_last) last_cyc_q.push_back(cyc);
         @(posedge clk);
         #1;
         if (b == gap_after) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_err   = 1'b0;
            repeat (gap_len) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic wait_lasts(input int n, input string tag);
      int t;
      t = 0;
      while (rec_q.size() < n && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (rec_q.size() < n) check_eq({tag, "_timeout"}, 64'(rec_q.size()), 64'(n));
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic check_payload(input string tag);
      int mism;
      mism = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= rx_q.size()) mism++;
         else if (rx_q[i] !== exp_q[i]) mism++;
      end
      check_eq({tag, "_paylen"}, 64'(rx_q.size()), 64'(exp_q.size()));
      check_eq({tag, "_paydata"}, 64'(mism), 64'd0);
      check_eq({tag, "_flagviol"}, 64'(viol_cnt), 64'd0);
   endtask

   task automatic check_last(input string tag, input int idx, input logic [7:0] keep,
                             input bit fcs, input bit len, input bit phy, input int lat);
      if (idx >= rec_q.size() || idx >= last_cyc_q.size()) begin
         check_eq({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         check_eq({tag, "_keep"}, 64'(rec_q[idx].keep), 64'(keep));
         check_eq({tag, "_fcs"}, 64'(rec_q[idx].fcs), 64'(fcs));
         check_eq({tag, "_len"}, 64'(rec_q[idx].len), 64'(len));
         check_eq({tag, "_phy"}, 64'(rec_q[idx].phy), 64'(phy));
         check_eq({tag, "_lat"}, 64'(rec_q[idx].cyc - last_cyc_q[idx]), 64'(lat));
      end
   endtask

   task automatic check_stats(input string tag, input int good, input int bad, input int len);
      check_eq({tag, "_good"}, 64'(stat_good), 64'(good));
      check_eq({tag, "_badfcs"}, 64'(stat_bad_fcs), 64'(bad));
      check_eq({tag, "_lenerr"}, 64'(stat_len_err), 64'(len));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cv[13];
      rst = 1'b0;
      idle();
      clear_mon();

      // Reset state.
      do_reset();
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_last", 64'(out_last), 64'd0);
      check_eq("rst_data", out_data, 64'd0);
      check_stats("rst", 0, 0, 0);

      // Minimum good frame: 7 full beats plus last keep 0x0F, two cycles after in_last.
      do_reset();
      build_frame(64, 1);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(1, "min");
      check_payload("min");
      check_last("min", 0, 8'h0F, 1'b0, 1'b0, 1'b0, 2);
      check_eq("min_beats", 64'(beat_cnt), 64'd8);
      check_eq("min_short", 64'(short_cnt), 64'd0);
      check_stats("min", 1, 0, 0);

      // Two 66-byte frames back to back: last payload keep 0x3F, one cycle after in_last.
      do_reset();
      build_frame(66, 2);
      send_frame(-1, 0, -1, 1'b0, -1);
      build_frame(66, 3);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(2, "b2b");
      check_payload("b2b");
      check_last("b2b0", 0, 8'h3F, 1'b0, 1'b0, 1'b0, 1);
      check_last("b2b1", 1, 8'h3F, 1'b0, 1'b0, 1'b0, 1);
      check_eq("b2b_beats", 64'(beat_cnt), 64'd16);
      check_stats("b2b", 2, 0, 0);

      // CRC check vector "123456789" + 26 39 F4 CB: good CRC, too short.
      do_reset();
      cv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
             8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
      tx_q.delete();
      for (int i = 0; i < 13; i++) begin
         tx_q.push_back(cv[i]);
         if (i < 9) exp_q.push_back(cv[i]);
      end
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(1, "cv");
      check_payload("cv");
      check_last("cv", 0, 8'h01, 1'b0, 1'b1, 1'b0, 2);
      if (rec_q.size() > 0) check_eq("cv_lastdata", rec_q[0].data, 64'h39);
      check_eq("cv_beats", 64'(beat_cnt), 64'd2);
      check_stats("cv", 0, 0, 1);

      // Corrupted FCS: bit 3 of byte 20 flipped after the FCS was computed.
      do_reset();
      build_frame(64, 4);
      tx_q[20]  = tx_q[20] ^ 8'h08;
      exp_q[20] = exp_q[20] ^ 8'h08;
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(1, "crc");
      check_payload("crc");
      check_last("crc", 0, 8'h0F, 1'b1, 1'b0, 1'b0, 2);
      check_stats("crc", 0, 1, 0);

      // 128-byte frame, 3-cycle gap after beat 5, in_err on beat 2, junk keep on non-last.
      do_reset();
      build_frame(128, 5);
      send_frame(5, 3, 2, 1'b1, -1);
      idle();
      wait_lasts(1, "gap");
      check_payload("gap");
      check_last("gap", 0, 8'h0F, 1'b0, 1'b0, 1'b1, 2);
      check_eq("gap_beats", 64'(beat_cnt), 64'd16);
      check_stats("gap", 0, 0, 0);

      // Length boundaries: 1518 bytes legal, 1519 bytes too long.
      do_reset();
      build_frame(1518, 6);
      send_frame(-1, 0, -1, 1'b0, -1);
      build_frame(1519, 7);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(2, "max");
      check_payload("max");
      check_last("max0", 0, 8'h03, 1'b0, 1'b0, 1'b0, 2);
      check_last("max1", 1, 8'h07, 1'b0, 1'b1, 1'b0, 2);
      check_stats("max", 1, 0, 1);

      // 3-byte frame: nothing emitted, length error still counted.
      do_reset();
      tx_q.delete();
      tx_q.push_back(8'hAA);
      tx_q.push_back(8'hBB);
      tx_q.push_back(8'hCC);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      repeat (5) begin @(posedge clk); #1; end
      check_eq("tiny_beats", 64'(beat_cnt), 64'd0);
      check_eq("tiny_lens", 64'(stat_len_err), 64'd1);
      check_eq("tiny_good", 64'(stat_good), 64'd0);

      // Reset mid-frame clears outputs and counters at once; next frame is checked normally.
      do_reset();
      build_frame(64, 8);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(1, "pre");
      check_eq("pre_good", 64'(stat_good), 64'd1);
      build_frame(128, 9);
      send_frame(-1, 0, -1, 1'b0, 4);
      #2 rst = 1'b0;
      #1;
      check_eq("mrst_valid", 64'(out_valid), 64'd0);
      check_eq("mrst_data", out_data, 64'd0);
      check_eq("mrst_keep", 64'(out_keep), 64'd0);
      check_eq("mrst_good", 64'(stat_good), 64'd0);
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      clear_mon();
      build_frame(64, 10);
      send_frame(-1, 0, -1, 1'b0, -1);
      idle();
      wait_lasts(1, "post");
      check_payload("post");
      check_last("post", 0, 8'h0F, 1'b0, 1'b0, 1'b0, 2);
      check_stats("post", 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rx_fcs_check.md
# eth_rx_fcs_check

Receive-side Ethernet FCS checker. It sits between the 64-bit RX PCS/MAC decode stream and the user RX interface. It computes CRC-32 over every received byte including the trailing 4-byte FCS, strips the FCS from the outgoing stream, and flags each frame's CRC, length and PHY errors on its last beat. It also keeps saturating per-frame statistics counters.

## Interface
- MIN_FRAME, 64: minimum legal frame length in bytes, FCS included.
- MAX_FRAME, 1518: maximum legal frame length in bytes, FCS included.

Ports (clock and reset first):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  64  received bytes; byte 0 = bits [7:0] = earliest on the wire.
- in_keep  input  8  byte enables; contiguous from bit 0; only meaningful on the last beat.
- in_valid  input  1  beat present. There is no backpressure; every valid beat is consumed.
- in_last  input  1  final beat of the frame.
- in_err  input  1  PCS decode error on this beat.
- out_data  output  64  payload bytes, FCS removed.
- out_keep  output  8  byte enables of out_data.
- out_valid  output  1  output beat present.
- out_last  output  1  final payload beat.
- out_fcs_err  output  1  CRC residue mismatch; valid only with out_valid & out_last.
- out_len_err  output  1  frame length < MIN_FRAME or > MAX_FRAME; valid with out_last.
- out_phy_err  output  1  in_err was seen on any beat of the frame; valid with out_last.
- stat_good  output  32  frames with no error.
- stat_bad_fcs  output  32  frames with out_fcs_err.
- stat_len_err  output  32  frames with out_len_err.

## Operation
- **CRC arithmetic.**
  - Reflected CRC-32, polynomial 0x04C11DB7 (LSB-first form 0xEDB88320).
  - Register initialised to 0xFFFFFFFF at frame start. Bytes are processed in byte-lane order, keep-enabled lanes only.
  - After the last byte, the uncomplemented register must equal 0xDEBB20E3; any other value sets fcs_err.
  - The register reinitialises after each in_last beat.
- **Non-last beats.** Treated as in_keep = 0xFF regardless of the actual value.
- **FCS strip (one-beat hold register, state EMPTY / HOLD / FLUSH).**
  - *Non-last beat arrives:*
    - If HOLD, the held beat is emitted (keep 0xFF, last=0).
    - The new beat is then loaded and the state becomes HOLD.
  - *Last beat with n = popcount(in_keep) ≤ 4:*
    - The held beat is emitted with its top (4−n) bytes removed: keep = (1<<(4+n))−1, last=1.
    - Next state is EMPTY.
    - If the state was EMPTY (the frame is ≤ 4 bytes total), nothing is emitted. Counters still update, with len_err set.
  - *Last beat with n > 4:*
    - Any held beat is emitted (last=0).
    - The new beat is loaded with keep = (1<<(n−4))−1 and the state becomes FLUSH.
    - In FLUSH, the held beat is emitted the next cycle with last=1 whether or not in_valid is high. A beat arriving in that same cycle loads normally, so back-to-back frames need no idle.
- **Length.**
  - A 16-bit byte counter accumulates n per beat and saturates at 0xFFFF.
  - len_err = total < MIN_FRAME or total > MAX_FRAME.
- **phy_err.** Sticky OR of in_err over the frame; cleared at frame end.
- **Statistics.**
  - One update per frame at its in_last beat. Each counter saturates at 0xFFFFFFFF.
  - stat_good increments only if fcs_err, len_err and phy_err are all 0.
  - A frame may increment both stat_bad_fcs and stat_len_err.
- **Gaps.** in_valid may drop mid-frame. Hold, CRC and counters are frozen while in_valid=0, except for the FLUSH emission.
- **Reset.**
  - Asynchronous and immediate: all outputs and counters go to 0, the state goes to EMPTY, and the CRC register goes to 0xFFFFFFFF.
  - Beats received after reset release form a frame terminated by the next in_last, which is checked normally.

## Timing
- All outputs are registered. out_valid is high for exactly one cycle per emitted beat.
- A non-last payload beat appears one cycle after the cycle in which the following input beat is accepted.
- out_last beat:
  - Appears 1 cycle after in_last when n ≤ 4.
  - Appears 2 cycles after in_last when n > 4.
- out_fcs_err, out_len_err and out_phy_err are asserted only in the out_last cycle; they are 0 otherwise.
- Statistics counters update on the clock edge that ends the in_last cycle, so they are visible 1 cycle after in_last.

## Test plan
- **Minimum good frame.** 64-byte frame, 8 beats, last keep 0xFF, correct FCS.
  - Expect 60 payload bytes: 7 beats with keep 0xFF plus a last beat with keep 0x0F, 2 cycles after in_last.
  - Expect all error flags 0 and stat_good=1.
- **Short last beat, no idle.** 66-byte good frame (last keep 0x03) followed immediately by another 66-byte frame.
  - Expect each frame's last payload beat with keep 0x3F, 1 cycle after its in_last.
  - Expect no beat loss and stat_good=2.
- **Check vector.** "123456789" followed by FCS bytes 26 39 F4 CB: beat0 keep 0xFF, beat1 keep 0x1F last.
  - Expect beat0 out (last=0), then a beat with keep 0x01, data 0x39, last=1.
  - Expect fcs_err=0, len_err=1, stat_len_err=1, stat_good=0.
- **Corrupted FCS.** Flip bit 3 of byte 20 in a 64-byte good frame.
  - Expect out_fcs_err=1 and stat_bad_fcs=1; payload still delivered.
- **Gaps and PHY error.** 128-byte frame with in_valid dropped for 3 cycles after beat 5, and in_err pulsed on beat 2.
  - Expect the payload unchanged and phy_err=1.
- **Reset mid-frame.** Pull rst low during beat 4 of a 128-byte frame.
  - Expect all outputs 0 immediately.
  - Then send a 64-byte good frame: expect it to pass with stat_good=1.
